// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// DATA_BITS mirrors the beat width used by the CPU-side definitions.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DATA_BITS = 8;

  // Occupancy needs one extra bit over the FIFO address width.
  localparam int COUNT_EXTRA_BITS = 1;

  function automatic int count_width(input int fifo_depth);
    return fifo_depth + COUNT_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational winner selection for the write-port arbiter.
// FIFO_ARB_FIXED_PRIO_EN selects lowest-index-first; otherwise round-robin from rr_ptr.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  logic             found;
  logic [PTR_W-1:0] idx;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  always_comb begin
    winner    = '0;
    any_valid = |req;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'(k);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner    = '0;
    any_valid = |req;
    found     = 1'b0;
    idx       = '0;
    // Scan cyclically starting at rr_ptr; first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst arbiter sharing one FIFO write port; owns the FIFO occupancy count.
// Build option: FIFO_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
//
// state | meaning
// IDLE  | no owner; pick a winner when any requester is valid and FIFO not full
// BURST | grant held; accept up to BURST_LEN beats, release on drop of valid
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             grant_o,
  input  logic                           rd_req_i,
  output logic                           rd_valid_o,
  output logic                           fifo_wen_o,
  output logic                           fifo_ren_o,
  output logic [DATA_BITS-1:0]           fifo_data_o,
  output logic [FIFO_DEPTH:0]            count_o
);

  localparam int CNT_W  = count_width(FIFO_DEPTH);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CAP    = (2 ** FIFO_DEPTH) - 1;
  localparam int BEAT_W = 4;

  arb_state_e         state, state_nx;
  logic [NUM_REQ-1:0] grant, grant_nx;
  logic [BEAT_W-1:0]  beat_cnt, beat_nx;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] winner;
  logic               any_valid;
  logic               full, empty;
  logic               wen, ren;
  logic               release_burst;

  assign full  = (count == CNT_W'(CAP));
  assign empty = (count == '0);

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  assign next_ptr = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    beat_nx       = beat_cnt;
    release_burst = 1'b0;
    req_ready_o   = '0;
    wen           = 1'b0;
    fifo_data_o   = '0;
    case (state)
      IDLE: begin
        if (any_valid && !full) begin
          grant_nx = winner;
          state_nx = BURST;
        end
      end
      BURST: begin
        req_ready_o = full ? '0 : grant;
        if (!req_valid_i[gidx]) begin
          release_burst = 1'b1;
        end else if (!full) begin
          wen         = 1'b1;
          fifo_data_o = req_data_i[int'(gidx)*DATA_BITS +: DATA_BITS];
          if (beat_cnt == BEAT_W'(BURST_LEN - 1)) release_burst = 1'b1;
          else                                    beat_nx = beat_cnt + BEAT_W'(1);
        end
        // Full with valid held: nothing moves until a read frees a slot.
        if (release_burst) begin
          state_nx = IDLE;
          grant_nx = '0;
          beat_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        beat_nx  = '0;
      end
    endcase
  end

  assign ren = rd_req_i & !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      beat_cnt <= beat_nx;
      count    <= count + CNT_W'(wen) - CNT_W'(ren);
    end
  end

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;

  logic unused_next_ptr;
  assign unused_next_ptr = ^next_ptr;
`else
  always_ff @(posedge clk) begin
    if (!rst)               rr_ptr <= '0;
    else if (release_burst) rr_ptr <= next_ptr;
  end
`endif

  assign grant_o    = grant;
  assign fifo_wen_o = wen;
  assign fifo_ren_o = ren;
  assign rd_valid_o = !empty;
  assign count_o    = count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter; honours FIFO_ARB_FIXED_PRIO_EN.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NUM_REQ = 4;

  logic                         clk;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ*DATA_BITS-1:0] req_data_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ-1:0]           grant_o;
  logic                         rd_req_i;
  logic                         rd_valid_o;
  logic                         fifo_wen_o;
  logic                         fifo_ren_o;
  logic [DATA_BITS-1:0]         fifo_data_o;
  logic [4:0]                   count_o;

  int n_vec;
  int n_miscmp;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .FIFO_DEPTH (4),
    .BURST_LEN  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .rd_req_i    (rd_req_i),
    .rd_valid_o  (rd_valid_o),
    .fifo_wen_o  (fifo_wen_o),
    .fifo_ren_o  (fifo_ren_o),
    .fifo_data_o (fifo_data_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req_valid_i = '0;
    rd_req_i    = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  logic [7:0]         pat;
  int                 acc;
  logic [NUM_REQ-1:0] owners [8];
  int                 beats  [8];
  int                 nb;
  logic [NUM_REQ-1:0] prev_g;
  logic [NUM_REQ-1:0] exp_owner [5];
  logic [NUM_REQ-1:0] exp_after_release;

  initial begin
    n_vec       = 0;
    n_miscmp    = 0;
    rst         = 1'b0;
    req_valid_i = '0;
    rd_req_i    = 1'b0;
    req_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp_owner         = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_after_release = 4'b0010;
`else
    exp_owner         = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_after_release = 4'b0100;
`endif

    // Reset held with every input active
    req_valid_i = 4'hF;
    rd_req_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("rst_grant", grant_o, 0);
      check_val("rst_ready", req_ready_o, 0);
      check_val("rst_count", count_o, 0);
      check_val("rst_rdvalid", rd_valid_o, 0);
      check_val("rst_wen", fifo_wen_o, 0);
      check_val("rst_ren", fifo_ren_o, 0);
    end

    // Single requester, 6 beats: idle, 4 beats, idle, 2 beats
    do_reset();
    req_valid_i = 4'b0100;
    #1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      pat[i] = fifo_wen_o;
      if (fifo_wen_o) begin
        acc++;
        check_val("single_data", fifo_data_o, 8'hA2);
      end
      cyc();
    end
    req_valid_i = '0;
    #1;
    check_val("single_pattern", pat, 8'hDE);
    check_val("single_beats", acc, 6);
    check_val("single_count", count_o, 6);
    check_val("single_grant_held", grant_o, 4'b0100);
    cyc();
    check_val("single_grant_release", grant_o, 0);

    // All requesters valid with a draining consumer
    do_reset();
    req_valid_i = 4'hF;
    rd_req_i    = 1'b1;
    #1;
    nb     = 0;
    prev_g = '0;
    for (int i = 0; i < 25; i++) begin
      if (grant_o != 0 && prev_g == 0 && nb < 8) begin
        owners[nb] = grant_o;
        beats[nb]  = 0;
        nb++;
      end
      if (fifo_wen_o && nb > 0) beats[nb-1] = beats[nb-1] + 1;
      prev_g = grant_o;
      cyc();
    end
    req_valid_i = '0;
    rd_req_i    = 1'b0;
    check_val("rr_num_bursts", nb, 5);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("rr_owner%0d", i), owners[i], exp_owner[i]);
      check_val($sformatf("rr_beats%0d", i), beats[i], 4);
    end

    // Full boundary: fill to 15 without reads
    do_reset();
    req_valid_i = 4'b0001;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (count_o == 15) break;
      cyc();
    end
    check_val("full_reached", count_o, 15);
    check_val("full_ready", req_ready_o, 0);
    check_val("full_wen", fifo_wen_o, 0);
    check_val("full_grant_held", grant_o, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("full_stall_wen", fifo_wen_o, 0);
      check_val("full_stall_count", count_o, 15);
    end
    rd_req_i = 1'b1;
    #1;
    check_val("full_rd_ren", fifo_ren_o, 1);
    check_val("full_rd_wen", fifo_wen_o, 0);
    check_val("full_rd_count", count_o, 15);
    cyc();
    rd_req_i = 1'b0;
    #1;
    check_val("full_after_rd_count", count_o, 14);
    check_val("full_after_rd_wen", fifo_wen_o, 1);
    check_val("full_after_rd_data", fifo_data_o, 8'hA0);
    cyc();
    check_val("full_refill_count", count_o, 15);
    req_valid_i = '0;

    // Empty boundary: read request on empty, then first write
    do_reset();
    rd_req_i    = 1'b1;
    req_valid_i = 4'b1000;
    #1;
    check_val("empty_ren", fifo_ren_o, 0);
    check_val("empty_rdvalid", rd_valid_o, 0);
    cyc();
    check_val("empty_first_wen", fifo_wen_o, 1);
    check_val("empty_first_ren", fifo_ren_o, 0);
    check_val("empty_first_data", fifo_data_o, 8'hA3);
    cyc();
    check_val("empty_next_count", count_o, 1);
    check_val("empty_next_rdvalid", rd_valid_o, 1);
    check_val("empty_next_ren", fifo_ren_o, 1);
    req_valid_i = '0;
    rd_req_i    = 1'b0;

    // Early release by requester 1 after two beats
    do_reset();
    req_valid_i = 4'b0010;
    #1;
    check_val("early_idle_wen", fifo_wen_o, 0);
    cyc();
    check_val("early_beat1", fifo_wen_o, 1);
    cyc();
    check_val("early_beat2", fifo_wen_o, 1);
    cyc();
    req_valid_i = '0;
    #1;
    check_val("early_drop_grant", grant_o, 4'b0010);
    check_val("early_drop_wen", fifo_wen_o, 0);
    cyc();
    req_valid_i = 4'b0110;
    #1;
    check_val("early_idle_grant", grant_o, 0);
    check_val("early_count", count_o, 2);
    cyc();
    check_val("early_next_owner", grant_o, exp_after_release);

    // Reset mid-burst clears everything at once
    rst = 1'b0;
    cyc();
    check_val("abort_grant", grant_o, 0);
    check_val("abort_count", count_o, 0);
    check_val("abort_wen", fifo_wen_o, 0);
    rst         = 1'b1;
    req_valid_i = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one FIFO instance among NUM_REQ requesters using round-robin burst arbitration. The FIFO has no full/empty outputs, so this block keeps the authoritative occupancy count. It gates the FIFO's wen_i/ren_i so the FIFO never overflows or underflows. It sits between the CNN accelerator's producer engines and the shared output buffer FIFO.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- FIFO_DEPTH, 4, log2 of FIFO entries; must match the attached FIFO.
- BURST_LEN, 4, maximum beats per grant before re-arbitration (1..15).
- Usable capacity CAP = 2**FIFO_DEPTH - 1 entries, because one slot is reserved by the FIFO pointer scheme.

Ports:
- clk, in, 1: single clock, all logic on its rising edge.
- rst, in, 1: reset, synchronous, active-low; asserted when rst==0, sampled on posedge clk.
- req_valid_i, in, NUM_REQ: per-requester beat valid.
- req_data_i, in, NUM_REQ*DATA_BITS: packed write data; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
- req_ready_o, out, NUM_REQ: per-requester beat accepted.
- grant_o, out, NUM_REQ: one-hot current owner, all zero when idle.
- rd_req_i, in, 1: consumer requests a pop.
- rd_valid_o, out, 1: FIFO non-empty, so the FIFO's data_o is valid.
- fifo_wen_o, out, 1: drives FIFO wen_i.
- fifo_ren_o, out, 1: drives FIFO ren_i.
- fifo_data_o, out, DATA_BITS: drives FIFO data_i.
- count_o, out, FIFO_DEPTH+1: current occupancy.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, count=0. All outputs are 0 in the cycle after reset.
- full = (count==CAP); empty = (count==0). Both are derived from the registered count only.
- States:
  - IDLE: if any req_valid_i is high and !full, latch the winner into grant and go to BURST.
  - Winner selection: first valid index at or after rr_ptr, searching cyclically.
  - No beat is accepted in IDLE, so first-beat latency is 1 cycle after valid.
- BURST:
  - req_ready_o[g] = (grant==g) & !full. All other ready bits are 0.
  - Beat accepted when req_valid_i[g] & req_ready_o[g]. Then fifo_wen_o=1, fifo_data_o = slice g, beat_cnt++.
  - Exit to IDLE after the beat where beat_cnt reaches BURST_LEN, or on any cycle where req_valid_i[g]==0.
  - On exit: rr_ptr = (g+1) mod NUM_REQ, beat_cnt=0, grant=0.
  - Full stalls the burst: state is held, the counter is not advanced, and the requester keeps valid.
- Read side:
  - fifo_ren_o = rd_req_i & !empty.
  - rd_valid_o = !empty. Both are combinational from count.
- Count update: count += fifo_wen_o - fifo_ren_o. A simultaneous write and read leaves count unchanged.
- At full, a read is allowed and a write is blocked in the same cycle. The freed slot is usable from the next cycle.
- fifo_data_o = 0 when fifo_wen_o==0.
- Reset during a BURST aborts it immediately. No partial state survives. The FIFO must be reset in the same cycle.

Optional Feature:
- Macro FIFO_ARB_FIXED_PRIO_EN.
- Defined: winner selection is fixed priority, lowest index first. rr_ptr is not implemented and stays 0.
- Undefined: round-robin as specified above.
- Burst and handshake rules are identical in both cases.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum arb_state_e {IDLE, BURST};
  - the width helper localparam for count;
  - DATA_BITS, taken from the shared CPU definitions header.
- Sub-module rr_picker: purely combinational. Inputs are the req vector and rr_ptr; outputs are a one-hot winner and an any_valid flag. Its fixed-priority variant is selected by the macro.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all valids high → grant_o=0, ready=0, count_o=0, rd_valid_o=0.
- Single requester: req 2 streams 6 beats with BURST_LEN=4 → 4 beats accepted, 1 idle re-arbitration cycle, then 2 beats accepted; count_o=6.
- Round-robin: all 4 requesters valid continuously → grant order 0,1,2,3,0. Each burst is exactly 4 beats with no starvation. With FIFO_ARB_FIXED_PRIO_EN defined, only requester 0 is granted.
- Full boundary: fill to 15 with no reads → ready drops at count_o=15 and fifo_wen_o never fires. A read while a write is pending → fifo_ren_o=1 and count stays 15 for one cycle, then the write lands.
- Empty boundary: rd_req_i=1 with count_o=0 → fifo_ren_o=0. A simultaneous first write gives count_o=1 and rd_valid_o=1 on the next cycle.
- Early release: req 1 drops valid after 2 beats → grant returns to 0 next cycle and rr_ptr=2.
